fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences the instruction fetch unit's PC register against a req/gnt/rvalid instruction-memory port.
- Decides when the PC advances (pc_enable, next_pc) and holds one fetched instruction for decode.
- Handles redirects from branches/jumps and back-pressure from decode.
- Sits between the fetch unit, the instruction memory (or bus bridge) and decode; keeps at most one memory request outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without rvalid before the fetch is abandoned and retried; range 1..255.
- CNT_W, 32: width of fetch_count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- pc  input  32  current PC from the fetch unit
- pc_plus4  input  32  pc+4 from the fetch unit
- pc_enable  output  1  load next_pc into the fetch unit this edge
- next_pc  output  32  PC value to load
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  32  redirect target
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address (= pc)
- imem_gnt  input  1  memory accepted request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- instr_valid  output  1  held instruction valid to decode
- instr  output  32  held instruction
- instr_pc  output  32  PC of held instruction
- instr_ready  input  1  decode accepts instr this cycle (low = stall)
- misaligned  output  1  sticky: a redirect target had bits [1:0] != 0
- bus_err  output  1  sticky: a fetch timed out
- fetch_count  output  CNT_W  instructions delivered to decode

Behaviour:
- States: BOOT, REQ, WAIT, HOLD.
- Reset: state=BOOT, kill=0, timer=0. Registered outputs instr_valid, instr, instr_pc, misaligned, bus_err, fetch_count are all 0.
- pc_enable and next_pc are combinational. While reset is high they are 0.
- imem_req=1 only in REQ; imem_addr=pc always. The fetch unit updates pc on the same edge pc_enable is sampled.
- BOOT: one cycle, then REQ. Gives the fetch unit time to present pc=0.
- REQ: imem_req=1.
  - gnt=1 -> WAIT, timer=0.
  - gnt=0 -> stay in REQ; the address may change while ungranted.
- WAIT: timer increments each cycle.
  - rvalid=1 and kill=0 -> capture instr=imem_rdata and instr_pc=pc; instr_valid=1 next cycle; -> HOLD.
  - rvalid=1 and kill=1 -> discard the data, clear kill, -> REQ.
  - timer reaches TIMEOUT_CYCLES-1 with no rvalid -> set bus_err, clear kill, -> REQ (retry same pc).
  - Memory must not return rvalid for an abandoned request.
- HOLD: instr_valid=1.
  - instr_ready=1 -> pc_enable=1, next_pc=pc_plus4, fetch_count+1 (wraps at 2^CNT_W), instr_valid=0, -> REQ.
  - instr_ready=0 -> hold all instr outputs stable.
- Redirect (redirect_valid=1) has priority over instr_ready in every state:
  - Drives pc_enable=1 and next_pc={redirect_pc[31:2],2'b00}.
  - Sets misaligned if redirect_pc[1:0]!=0.
  - BOOT -> REQ.
  - REQ, gnt=0 -> stay in REQ; the next request uses the new pc.
  - REQ, gnt=1 -> WAIT with kill=1, because the granted fetch is for the old pc.
  - WAIT, no rvalid -> kill=1, stay in WAIT.
  - WAIT, rvalid the same cycle -> discard the data, -> REQ.
  - HOLD -> drop the held instruction (instr_valid=0 next cycle, no count), -> REQ. Simultaneous instr_ready=1 is ignored.
- instr_ready while instr_valid=0 is ignored.
- One outstanding request maximum: no imem_req from gnt until the response or timeout.
- Fetch throughput is at best one instruction per 3 cycles (REQ, WAIT, HOLD) with single-cycle gnt and rvalid.
- Reset in any state returns immediately to the reset values. An in-flight response after reset is ignored: BOOT and REQ never sample rvalid.

Test Plan:
- Boot, zero-wait memory:
  - Stimulus: release reset; gnt=1 same cycle as req; rvalid next cycle with rdata=0x00000013; instr_ready=1.
  - Required: instr=0x13, instr_pc=0; pc_enable pulses with next_pc=4; fetch_count=1; second request addr=4.
- Stall:
  - Stimulus: hold instr_ready=0 for 5 cycles in HOLD.
  - Required: instr, instr_pc and instr_valid stable; no pc_enable; no imem_req; release -> single pc_enable, next_pc=pc+4.
- Redirect during WAIT:
  - Stimulus: redirect_valid with redirect_pc=0x100 while awaiting rvalid; stale rdata=0xDEADBEEF arrives later.
  - Required: stale data never reaches instr_valid; next imem_addr=0x100; fetch_count unchanged.
- Redirect in HOLD with instr_ready=1 in the same cycle:
  - Required: next_pc=redirect target, not pc+4; held instruction dropped; count not incremented.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x203.
  - Required: next_pc=0x200; misaligned=1 and stays set until reset.
- Timeout with TIMEOUT_CYCLES=4:
  - Stimulus: grant the request, never assert rvalid.
  - Required: bus_err=1 after 4 WAIT cycles; re-request with the same imem_addr. Then reset mid-WAIT: all outputs return to 0, then BOOT->REQ with addr=0.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller
// Sequences the fetch unit's PC against a req/gnt/rvalid instruction memory
// port. It keeps at most one request outstanding and holds one fetched
// instruction for decode. It also handles branch/jump redirects and decode
// back-pressure.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pc, pc_plus4          current PC and PC+4 from the fetch unit
//   pc_enable, next_pc    load request into the fetch unit (combinational)
//   redirect_valid/_pc    branch/jump taken and its target
//   imem_req/_addr        fetch request and address (address is always pc)
//   imem_gnt              memory accepted the request
//   imem_rvalid/_rdata    read response
//   instr_valid/instr/instr_pc  held instruction for decode
//   instr_ready           decode accepts the held instruction
//   misaligned            sticky: a redirect target was not word aligned
//   bus_err               sticky: a fetch timed out
//   fetch_count           instructions delivered to decode
//
// state | meaning
// BOOT  | one cycle after reset so the fetch unit can present pc=0
// REQ   | request driven, waiting for gnt
// WAIT  | granted, waiting for rvalid (timer running)
// HOLD  | instruction held for decode
module fetch_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [31:0]      pc_plus4,
    output logic             pc_enable,
    output logic [31:0]      next_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    input  logic             instr_ready,
    output logic             misaligned,
    output logic             bus_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic       kill;   // the outstanding response belongs to a stale pc
    logic [7:0] timer;

    // Redirect wins over decode acceptance; the fetch unit loads next_pc on
    // the same edge this controller samples its inputs.
    always_comb begin
        pc_enable = 1'b0;
        next_pc   = '0;
        if (!reset) begin
            if (redirect_valid) begin
                pc_enable = 1'b1;
                next_pc   = {redirect_pc[31:2], 2'b00};
            end else if (state == HOLD && instr_ready) begin
                pc_enable = 1'b1;
                next_pc   = pc_plus4;
            end
        end
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            kill        <= 1'b0;
            timer       <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            misaligned  <= 1'b0;
            bus_err     <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (redirect_valid && redirect_pc[1:0] != 2'b00)
                misaligned <= 1'b1;

            case (state)
                BOOT: state <= REQ;

                REQ: begin
                    // The address may follow a redirect while ungranted; a
                    // grant in the redirect cycle is for the old pc.
                    if (imem_gnt) begin
                        state <= WAIT;
                        timer <= '0;
                        kill  <= redirect_valid;
                    end
                end

                WAIT: begin
                    timer <= timer + 8'd1;
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (kill || redirect_valid) begin
                            state <= REQ;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (timer == TIMER_LAST) begin
                        // Abandon and retry at the current pc.
                        bus_err <= 1'b1;
                        kill    <= 1'b0;
                        state   <= REQ;
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + CNT_ONE;
                        state       <= REQ;
                    end
                end

                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller. It models the fetch unit's PC register and
// applies a table of directed per-cycle vectors. Hand-written sequences then
// cover the redirect and kill corner cases.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc = '0;
    logic [31:0] pc_plus4;
    logic        pc_enable;
    logic [31:0] next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misaligned;
    logic        bus_err;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    fetch_controller #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pc_enable      (pc_enable),
        .next_pc        (next_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .misaligned     (misaligned),
        .bus_err        (bus_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Fetch unit model: PC register loaded when pc_enable is sampled.
    always @(posedge clk) begin
        if (reset)          pc <= '0;
        else if (pc_enable) pc <= next_pc;
    end
    assign pc_plus4 = pc + 32'd4;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvl;
        logic [31:0] rd;
        logic        rdy;
        logic        en;
        logic [31:0] npc;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        mis;
        logic        berr;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic rst, input logic rv, input logic [31:0] rpc,
        input logic gnt, input logic rvl, input logic [31:0] rd, input logic rdy,
        input logic en, input logic [31:0] npc, input logic req, input logic [31:0] addr,
        input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
        input logic mis, input logic berr, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvl = rvl; v.rd = rd;
        v.rdy = rdy; v.en = en; v.npc = npc; v.req = req; v.addr = addr; v.iv = iv;
        v.ins = ins; v.ipc = ipc; v.mis = mis; v.berr = berr; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc,
                         input logic gnt, input logic rvl, input logic [31:0] rd,
                         input logic rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_gnt       = gnt;
        imem_rvalid    = rvl;
        imem_rdata     = rd;
        instr_ready    = rdy;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //   rst rv rpc       gnt rvl rd           rdy  en npc      req addr      iv ins          ipc       mis berr cnt
        // reset, boot, zero-wait fetch of 0x13 at pc 0
        add(1, 0, 32'h0,   0, 0, 32'h0,        0,  0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,  0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   1, 0, 32'h0,        0,  0, 32'h0,   1, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   0, 1, 32'h13,       0,  0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   0, 0, 32'h0,        1,  1, 32'h4,   0, 32'h0,   1, 32'h13,       32'h0,   0, 0, 0);
        // second fetch at 4, then five stall cycles
        add(0, 0, 32'h0,   1, 0, 32'h0,        0,  0, 32'h0,   1, 32'h4,   0, 32'h13,       32'h0,   0, 0, 1);
        add(0, 0, 32'h0,   0, 1, 32'h500093,   0,  0, 32'h0,   0, 32'h4,   0, 32'h13,       32'h0,   0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 0, 32'h0, 0, 0, 32'h0,      0,  0, 32'h0,   0, 32'h4,   1, 32'h500093,   32'h4,   0, 0, 1);
        add(0, 0, 32'h0,   0, 0, 32'h0,        1,  1, 32'h8,   0, 32'h4,   1, 32'h500093,   32'h4,   0, 0, 1);
        // ready while nothing is held is ignored; ungranted then granted
        add(0, 0, 32'h0,   0, 0, 32'h0,        1,  0, 32'h0,   1, 32'h8,   0, 32'h500093,   32'h4,   0, 0, 2);
        add(0, 0, 32'h0,   1, 0, 32'h0,        1,  0, 32'h0,   1, 32'h8,   0, 32'h500093,   32'h4,   0, 0, 2);
        // redirect in WAIT, stale data discarded
        add(0, 1, 32'h100, 0, 0, 32'h0,        0,  1, 32'h100, 0, 32'h8,   0, 32'h500093,   32'h4,   0, 0, 2);
        add(0, 0, 32'h0,   0, 1, 32'hDEADBEEF, 0,  0, 32'h0,   0, 32'h100, 0, 32'h500093,   32'h4,   0, 0, 2);
        add(0, 0, 32'h0,   1, 0, 32'h0,        0,  0, 32'h0,   1, 32'h100, 0, 32'h500093,   32'h4,   0, 0, 2);
        add(0, 0, 32'h0,   0, 1, 32'h11111111, 0,  0, 32'h0,   0, 32'h100, 0, 32'h500093,   32'h4,   0, 0, 2);
        // misaligned redirect in HOLD with simultaneous ready
        add(0, 1, 32'h203, 0, 0, 32'h0,        1,  1, 32'h200, 0, 32'h100, 1, 32'h11111111, 32'h100, 0, 0, 2);
        add(0, 0, 32'h0,   1, 0, 32'h0,        0,  0, 32'h0,   1, 32'h200, 0, 32'h11111111, 32'h100, 1, 0, 2);
        // timeout after four WAIT cycles, retry at same address
        for (int i = 0; i < 4; i++)
            add(0, 0, 32'h0, 0, 0, 32'h0,      0,  0, 32'h0,   0, 32'h200, 0, 32'h11111111, 32'h100, 1, 0, 2);
        add(0, 0, 32'h0,   1, 0, 32'h0,        0,  0, 32'h0,   1, 32'h200, 0, 32'h11111111, 32'h100, 1, 1, 2);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,  0, 32'h0,   0, 32'h200, 0, 32'h11111111, 32'h100, 1, 1, 2);
        // reset mid-WAIT; late response ignored in BOOT and REQ
        add(1, 0, 32'h0,   0, 0, 32'h0,        0,  0, 32'h0,   0, 32'h200, 0, 32'h11111111, 32'h100, 1, 1, 2);
        add(0, 0, 32'h0,   0, 1, 32'hBAD,      0,  0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   0, 1, 32'hBAD,      0,  0, 32'h0,   1, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   1, 0, 32'h0,        0,  0, 32'h0,   1, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   0, 1, 32'h13,       0,  0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,  0, 32'h0,   0, 32'h0,   1, 32'h13,       32'h0,   0, 0, 0);

        foreach (vecs[i]) begin
            row = i;
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].gnt,
                  vecs[i].rvl, vecs[i].rd, vecs[i].rdy);
            #2;
            chk("pc_enable",   32'(pc_enable),   32'(vecs[i].en));
            chk("next_pc",     next_pc,          vecs[i].npc);
            chk("imem_req",    32'(imem_req),    32'(vecs[i].req));
            chk("imem_addr",   imem_addr,        vecs[i].addr);
            chk("instr_valid", 32'(instr_valid), 32'(vecs[i].iv));
            chk("instr",       instr,            vecs[i].ins);
            chk("instr_pc",    instr_pc,         vecs[i].ipc);
            chk("misaligned",  32'(misaligned),  32'(vecs[i].mis));
            chk("bus_err",     32'(bus_err),     32'(vecs[i].berr));
            chk("fetch_count", fetch_count,      vecs[i].cnt);
        end

        // Redirect in HOLD with ready low, then a redirect coinciding with gnt
        // in REQ: the granted response must be discarded via kill.
        row = 100;
        @(negedge clk); drive(0, 1, 32'h40, 0, 0, 32'h0, 1); #2;
        chk("hold_redir_en",  32'(pc_enable), 32'd1);
        chk("hold_redir_npc", next_pc, 32'h40);
        row = 101;
        @(negedge clk); drive(0, 1, 32'h80, 1, 0, 32'h0, 0); #2;
        chk("req_redir_req",  32'(imem_req), 32'd1);
        chk("req_redir_addr", imem_addr, 32'h40);
        chk("req_redir_npc",  next_pc, 32'h80);
        chk("req_redir_iv",   32'(instr_valid), 32'd0);
        chk("req_redir_cnt",  fetch_count, 32'd0);
        row = 102;
        @(negedge clk); drive(0, 0, 32'h0, 0, 1, 32'hBAD, 0); #2;
        chk("kill_wait_req",  32'(imem_req), 32'd0);
        chk("kill_wait_addr", imem_addr, 32'h80);
        row = 103;
        @(negedge clk); drive(0, 0, 32'h0, 1, 0, 32'h0, 0); #2;
        chk("kill_rereq",     32'(imem_req), 32'd1);
        chk("kill_rereq_addr", imem_addr, 32'h80);
        chk("kill_drop_iv",   32'(instr_valid), 32'd0);
        row = 104;
        @(negedge clk); drive(0, 0, 32'h0, 0, 1, 32'hCAFE0001, 0); #2;
        chk("refetch_req",    32'(imem_req), 32'd0);
        row = 105;
        @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0, 0); #2;
        chk("refetch_iv",     32'(instr_valid), 32'd1);
        chk("refetch_instr",  instr, 32'hCAFE0001);
        chk("refetch_ipc",    instr_pc, 32'h80);
        chk("refetch_cnt",    fetch_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
